// File: rtl/image_frame_server_if.sv
// image_frame_server_if: pixel stream, accelerator image port and result port
// of the LeNet frame server, bundled so the server and its environment share
// one set of names. The server side uses the slave modport.
interface image_frame_server_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int FID_W  = 16
);
    // Pixel stream
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    // Accelerator image port
    logic              go;
    logic              cena_image;
    logic [ADDR_W-1:0] aa_image;
    logic [DATA_W-1:0] image_q;
    logic              ready;
    logic [3:0]        digit;

    // Result port and status
    logic              res_valid;
    logic              res_ready;
    logic [3:0]        res_digit;
    logic [FID_W-1:0]  res_frame_id;
    logic              err_spurious;

    modport slave (
        input  s_valid, s_data, cena_image, aa_image, ready, digit, res_ready,
        output s_ready, go, image_q, res_valid, res_digit, res_frame_id, err_spurious
    );

    modport master (
        output s_valid, s_data, cena_image, aa_image, ready, digit, res_ready,
        input  s_ready, go, image_q, res_valid, res_digit, res_frame_id, err_spurious
    );
endinterface

// File: rtl/image_frame_server.sv
// image_frame_server: packs a raster pixel stream into a ping-pong pair of frame
// banks, starts the LeNet accelerator with a one-cycle go, serves its image
// reads with 1-cycle registered data, and hands the classified digit to a
// valid/ready result port tagged with a running frame id.
module image_frame_server #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 10,
    parameter int FID_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    image_frame_server_if.slave bus
);
    localparam int                DEPTH    = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GO   = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [DATA_W-1:0] mem [2][DEPTH];
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W-1:0] wr_ptr;
    logic [FID_W-1:0]  frame_cnt;
    logic [1:0]        state;

    logic wr_en;
    logic wr_last;
    logic rd_in_range;
    logic capture;
    logic start_ok;

    // The stream only stalls when the bank it would write still holds a frame.
    assign bus.s_ready = !full[wr_bank];
    assign wr_en       = bus.s_valid && bus.s_ready;
    assign wr_last     = wr_en && (wr_ptr == LAST_PIX);
    assign rd_in_range = {1'b0, bus.aa_image} < DEPTH_X;
    assign capture     = (state == ST_RUN) && bus.ready;
    // An unaccepted result would be overwritten by the next capture, so hold off.
    assign start_ok    = full[rd_bank] && !(bus.res_valid && !bus.res_ready);
    assign bus.go      = (state == ST_GO);

    // Pixel storage: stream writes into the bank currently being filled.
    // NOTE: the frame banks have no reset; clearing every entry would stop them
    // mapping onto RAM, and no bank is read before it has been completely written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank][wr_ptr] <= bus.s_data;
    end

    // Registered read port on the bank being processed; holds while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all clocked state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement or block order.
        if (!rst_n) begin
            bus.image_q <= '0;
        end else if (!bus.cena_image) begin
            bus.image_q <= rd_in_range ? mem[rd_bank][bus.aa_image] : '0;
        end
    end

    // Next bank-full flags: the bank being read is released on capture, the bank
    // being written is marked full on its last pixel; these are never the same bank.
    always_comb begin
        // NOTE: start from the held value so every path assigns full_nxt; a
        // missing default here would infer a latch.
        full_nxt = full;
        if (capture) full_nxt[rd_bank] = 1'b0;
        if (wr_last) full_nxt[wr_bank] = 1'b1;
    end

    // Write-side bookkeeping: pixel pointer, bank toggle and full flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
            full    <= '0;
        end else begin
            full <= full_nxt;
            if (wr_en) wr_ptr <= wr_last ? '0 : wr_ptr + ADDR_W'(1);
            if (wr_last) wr_bank <= !wr_bank;
        end
    end

    // Control FSM: start the accelerator on a full bank, then wait for its done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            rd_bank <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start_ok) state <= ST_GO;
                ST_GO:   state <= ST_RUN;
                ST_RUN: begin
                    if (bus.ready) begin
                        state   <= ST_IDLE;
                        rd_bank <= !rd_bank;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result capture, hand-off and spurious-done flag; a capture wins over acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.res_valid    <= 1'b0;
            bus.res_digit    <= '0;
            bus.res_frame_id <= '0;
            frame_cnt        <= '0;
            bus.err_spurious <= 1'b0;
        end else begin
            if (capture) begin
                bus.res_valid    <= 1'b1;
                bus.res_digit    <= bus.digit;
                bus.res_frame_id <= frame_cnt;
                frame_cnt        <= frame_cnt + FID_W'(1);
            end else if (bus.res_valid && bus.res_ready) begin
                bus.res_valid <= 1'b0;
            end
            if (bus.ready && (state != ST_RUN)) bus.err_spurious <= 1'b1;
        end
    end
endmodule

// File: tb/tb_image_frame_server.sv
// tb_image_frame_server: directed stimulus for the frame server. A frame-level
// model (completed/released frame counts, per-frame pixel store, result register)
// predicts every output; one process compares it each cycle, and literal checks
// pin the model at the points the scenarios are built around.
module tb_image_frame_server;
    localparam int DATA_W = 8;
    localparam int IMG_W  = 32;
    localparam int IMG_H  = 32;
    localparam int ADDR_W = 10;
    localparam int FID_W  = 16;
    localparam int DEPTH  = IMG_W * IMG_H;
    localparam int IDX_W  = $clog2(DEPTH);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    image_frame_server_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FID_W(FID_W)) bus ();

    image_frame_server #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .FID_W(FID_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int go_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix(input int seed, input int i);
        return 8'(i + 16 * seed);
    endfunction

    // ---------------- frame-level model ----------------
    logic [7:0]       fstore [16][DEPTH];
    int               m_done   = 0;   // frames completely written since reset
    int               m_served = 0;   // frames released by a done pulse
    int               m_wptr   = 0;
    bit               m_go     = 0;
    bit               m_run    = 0;
    bit               m_res_valid = 0;
    logic [3:0]       m_res_digit = '0;
    logic [FID_W-1:0] m_res_id    = '0;
    logic [FID_W-1:0] m_fcnt      = '0;
    bit               m_err    = 0;
    logic [7:0]       m_q      = '0;
    bit               m_q_known = 1;

    task automatic model_reset();
        m_done = 0; m_served = 0; m_wptr = 0;
        m_go = 0; m_run = 0;
        m_res_valid = 0; m_res_digit = '0; m_res_id = '0; m_fcnt = '0;
        m_err = 0; m_q = '0; m_q_known = 1;
    endtask

    task automatic model_step();
        bit go_now;
        bit run_now;
        bit pend;
        int buffered;
        int a;
        go_now   = m_go;
        run_now  = m_run;
        pend     = m_res_valid && !bus.res_ready;
        buffered = m_done - m_served;
        // reads see the frame at the head of the buffer
        if (!bus.cena_image) begin
            a = int'(bus.aa_image);
            if (a >= DEPTH) begin
                m_q = '0; m_q_known = 1;
            end else if (buffered > 0) begin
                m_q = fstore[4'(m_served)][IDX_W'(a)]; m_q_known = 1;
            end else begin
                m_q_known = 0;
            end
        end
        // done pulse only counts while a started frame is being processed
        if (bus.ready && run_now) begin
            m_res_valid = 1; m_res_digit = bus.digit; m_res_id = m_fcnt;
            m_fcnt = m_fcnt + 1'b1;
            m_served++;
            m_run = 0;
        end else begin
            if (bus.ready) m_err = 1;
            if (m_res_valid && bus.res_ready) m_res_valid = 0;
        end
        // stream accepted while fewer than two frames are buffered
        if (bus.s_valid && buffered < 2) begin
            fstore[4'(m_done)][IDX_W'(m_wptr)] = bus.s_data;
            m_wptr++;
            if (m_wptr == DEPTH) begin
                m_wptr = 0;
                m_done++;
            end
        end
        if (go_now) m_run = 1;
        m_go = !run_now && !go_now && buffered > 0 && !pend;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("s_ready", 32'(bus.s_ready), 32'((m_done - m_served) < 2));
        check("go", 32'(bus.go), 32'(m_go));
        check("res_valid", 32'(bus.res_valid), 32'(m_res_valid));
        check("res_digit", 32'(bus.res_digit), 32'(m_res_digit));
        check("res_frame_id", 32'(bus.res_frame_id), 32'(m_res_id));
        check("err_spurious", 32'(bus.err_spurious), 32'(m_err));
        if (m_q_known) check("image_q", 32'(bus.image_q), 32'(m_q));
    end

    initial forever begin
        @(negedge clk);
        if (bus.go) go_count++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (enter/leave at posedge+1) ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.s_valid = 0; bus.ready = 0; bus.cena_image = 1;
        rst_n = 0;
        tick(1);
        rst_n = 1;
    endtask

    task automatic send_beats(input int seed, input int first, input int count,
                              input int stall_limit, output int sent);
        int stall;
        stall = 0;
        sent  = 0;
        while (sent < count && stall < stall_limit) begin
            bus.s_valid = 1;
            bus.s_data  = pix(seed, first + sent);
            @(negedge clk);
            if (bus.s_ready) begin
                sent++;
                stall = 0;
            end else begin
                stall++;
            end
            @(posedge clk);
            #1;
        end
        bus.s_valid = 0;
    endtask

    task automatic wait_go(input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.go) seen = 1;
        end
    endtask

    task automatic pulse_ready(input logic [3:0] d);
        bus.ready = 1;
        bus.digit = d;
        tick(1);
        bus.ready = 0;
    endtask

    task automatic read_px(input string name, input int addr, input logic [7:0] exp);
        bus.cena_image = 0;
        bus.aa_image   = ADDR_W'(addr);
        tick(1);
        bus.cena_image = 1;
        @(negedge clk);
        check(name, 32'(bus.image_q), 32'(exp));
        tick(1);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int  sent;
        int  g0;
        bit  seen;
        bus.s_valid = 0; bus.s_data = '0; bus.cena_image = 1; bus.aa_image = '0;
        bus.ready = 0; bus.digit = '0; bus.res_ready = 0;
        tick(2);
        rst_n = 1;

        // reset state
        @(negedge clk);
        check("rst_s_ready", 32'(bus.s_ready), 1);
        check("rst_go", 32'(bus.go), 0);
        check("rst_res_valid", 32'(bus.res_valid), 0);
        tick(1);

        // frame of i mod 256; go in the cycle after the bank becomes full
        send_beats(0, 0, DEPTH, 20, sent);
        check("s1_sent", sent, DEPTH);
        @(negedge clk);
        check("s1_go_early", 32'(bus.go), 0);
        @(negedge clk);
        check("s1_go_pulse", 32'(bus.go), 1);
        @(negedge clk);
        check("s1_go_once", 32'(bus.go), 0);
        tick(1);
        check("s1_go_count", go_count, 1);
        read_px("s1_rd_005", 5, 8'h05);
        read_px("s1_rd_3ff", 10'h3FF, 8'hFF);
        bus.aa_image = 10'h005;
        tick(2);
        @(negedge clk);
        check("s1_rd_hold", 32'(bus.image_q), 32'h0FF);
        tick(1);

        // result held while not accepted, cleared after acceptance
        pulse_ready(4'd7);
        @(negedge clk);
        check("s2_valid", 32'(bus.res_valid), 1);
        check("s2_digit", 32'(bus.res_digit), 7);
        check("s2_id", 32'(bus.res_frame_id), 0);
        repeat (20) @(negedge clk);
        check("s2_valid_held", 32'(bus.res_valid), 1);
        check("s2_digit_held", 32'(bus.res_digit), 7);
        tick(1);
        bus.res_ready = 1;
        tick(1);
        @(negedge clk);
        check("s2_accepted", 32'(bus.res_valid), 0);
        tick(1);

        // three frames back to back with no done pulse: both banks fill, stream stalls
        g0 = go_count;
        send_beats(1, 0, 3 * DEPTH, 20, sent);
        check("s3_sent", sent, 2 * DEPTH);
        @(negedge clk);
        check("s3_stalled", 32'(bus.s_ready), 0);
        check("s3_one_go", go_count - g0, 1);
        tick(1);
        pulse_ready(4'd3);
        @(negedge clk);
        check("s3_bank_freed", 32'(bus.s_ready), 1);
        check("s3_id", 32'(bus.res_frame_id), 1);
        wait_go(5, seen);
        check("s3_second_go", 32'(seen), 1);
        tick(1);
        read_px("s3_rd_frame2", 10, 8'd26);
        send_beats(1, 2 * DEPTH, DEPTH, 20, sent);
        check("s3_third_sent", sent, DEPTH);
        pulse_ready(4'd4);
        wait_go(5, seen);
        check("s3_third_go", 32'(seen), 1);
        tick(1);
        read_px("s3_rd_frame3", 0, 8'd16);
        pulse_ready(4'd5);

        // ten frames with the result always accepted
        do_reset();
        bus.res_ready = 1;
        g0 = go_count;
        for (int f = 0; f < 10; f++) begin
            send_beats(f + 2, 0, DEPTH, 20, sent);
            check("s4_sent", sent, DEPTH);
            wait_go(5, seen);
            check("s4_go", 32'(seen), 1);
            tick(1);
            pulse_ready(4'(f + 3));
            @(negedge clk);
            check("s4_valid", 32'(bus.res_valid), 1);
            check("s4_id", 32'(bus.res_frame_id), 32'(f));
            check("s4_digit", 32'(bus.res_digit), 32'(f + 3));
            tick(1);
        end
        check("s4_go_count", go_count - g0, 10);

        // pending result withholds the next start
        bus.res_ready = 0;
        g0 = go_count;
        send_beats(12, 0, 2 * DEPTH, 20, sent);
        check("s4b_sent", sent, 2 * DEPTH);
        pulse_ready(4'd11);
        @(negedge clk);
        check("s4b_id", 32'(bus.res_frame_id), 10);
        tick(10);
        check("s4b_withheld", go_count - g0, 1);
        bus.res_ready = 1;
        wait_go(5, seen);
        check("s4b_released", 32'(seen), 1);
        tick(1);
        pulse_ready(4'd12);
        @(negedge clk);
        check("s4b_id2", 32'(bus.res_frame_id), 11);
        tick(1);

        // done pulse in the GO cycle and in IDLE only raises the error flag
        do_reset();
        send_beats(13, 0, DEPTH, 20, sent);
        wait_go(5, seen);
        check("s5_go", 32'(seen), 1);
        bus.ready = 1;
        bus.digit = 4'd9;
        @(posedge clk);
        #1;
        bus.ready = 0;
        @(negedge clk);
        check("s5_err_go", 32'(bus.err_spurious), 1);
        check("s5_no_result", 32'(bus.res_valid), 0);
        tick(1);
        pulse_ready(4'd2);
        @(negedge clk);
        check("s5_run_result", 32'(bus.res_digit), 2);
        check("s5_err_sticky", 32'(bus.err_spurious), 1);
        tick(1);
        do_reset();
        @(negedge clk);
        check("s5_err_cleared", 32'(bus.err_spurious), 0);
        tick(1);
        send_beats(14, 0, 300, 20, sent);
        pulse_ready(4'd9);
        @(negedge clk);
        check("s5_err_idle", 32'(bus.err_spurious), 1);
        check("s5_idle_no_result", 32'(bus.res_valid), 0);
        tick(1);
        send_beats(14, 300, DEPTH - 300, 20, sent);
        wait_go(5, seen);
        check("s5_partial_kept", 32'(seen), 1);
        tick(1);
        read_px("s5_rd", 7, 8'd231);
        bus.res_ready = 0;
        pulse_ready(4'd6);

        // reset in the middle of a frame discards it
        send_beats(5, 0, 500, 20, sent);
        check("s6_partial", sent, 500);
        rst_n = 0;
        @(negedge clk);
        check("s6_go", 32'(bus.go), 0);
        check("s6_image_q", 32'(bus.image_q), 0);
        check("s6_res_valid", 32'(bus.res_valid), 0);
        check("s6_res_digit", 32'(bus.res_digit), 0);
        check("s6_res_id", 32'(bus.res_frame_id), 0);
        check("s6_err", 32'(bus.err_spurious), 0);
        check("s6_s_ready", 32'(bus.s_ready), 1);
        tick(1);
        rst_n = 1;
        bus.res_ready = 1;
        g0 = go_count;
        send_beats(6, 0, DEPTH, 20, sent);
        wait_go(5, seen);
        check("s6_go_after", 32'(seen), 1);
        tick(1);
        read_px("s6_rd_0", 0, 8'd96);
        read_px("s6_rd_499", 499, 8'd83);
        read_px("s6_rd_1023", 1023, 8'd95);
        pulse_ready(4'd1);
        check("s6_go_count", go_count - g0, 1);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/image_frame_server.md
Name: image_frame_server

Overview:
- Source-side responder for the LeNet co-processor image interface.
- Accepts a raw pixel byte stream and packs it into a 2-bank (ping-pong) frame buffer of IMG_W*IMG_H pixels per bank.
- Starts the accelerator with a one-cycle `go`, then answers its `cena_image`/`aa_image` reads with 1-cycle registered data.
- Captures `digit` when the accelerator asserts `ready`, and presents it on a valid/ready result port.
- Replaces the bench ROM plus go/ready sequencing in silicon.

Parameters:
- DATA_W, 8, pixel width on stream input and `image_q` output.
- IMG_W, 32, image width in pixels.
- IMG_H, 32, image height in pixels.
- ADDR_W, 10, width of `aa_image`. Requires IMG_W*IMG_H <= 2**ADDR_W.
- FID_W, 16, width of the frame id counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  pixel stream valid.
- s_ready  out  1  pixel stream ready (combinational from bank state).
- s_data  in  DATA_W  pixel, raster order, pixel 0 first.
- go  out  1  one-cycle start pulse to accelerator.
- cena_image  in  1  active-low read enable from accelerator.
- aa_image  in  ADDR_W  read address from accelerator.
- image_q  out  DATA_W  read data, registered.
- ready  in  1  accelerator done pulse; `digit` valid in that cycle.
- digit  in  4  classification result.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer accept.
- res_digit  out  4  captured digit.
- res_frame_id  out  FID_W  sequence number of the result.
- err_spurious  out  1  sticky; `ready` seen outside RUN.

Behaviour:
- Reset values: `go`=0, `image_q`=0, `res_valid`=0, `res_digit`=0, `res_frame_id`=0, `err_spurious`=0. Also: both banks empty, `wr_bank`=0, `rd_bank`=0, `wr_ptr`=0, `frame_cnt`=0, FSM=IDLE. Memory contents are not reset.
- Write side:
  - `s_ready` = !full[wr_bank].
  - A beat is accepted when `s_valid` && `s_ready`. It writes `mem[wr_bank][wr_ptr]`, then `wr_ptr`++.
  - On the beat with `wr_ptr` == IMG_W*IMG_H-1: `wr_ptr`->0, full[wr_bank]<=1, `wr_bank` toggles.
  - If both banks are full, `s_ready`=0 and the stream stalls; no data is dropped.
- Read port:
  - Each posedge with `cena_image`=0 loads `image_q` <= `mem[rd_bank][aa_image]`. Latency is exactly 1 cycle.
  - When `cena_image`=1, `image_q` holds its value.
  - Addresses >= IMG_W*IMG_H return 0.
  - Reads are served from `rd_bank` in every state.
  - A write to `wr_bank` and a read from `rd_bank` in the same cycle are independent.
  - A read of a bank while that same bank is being written cannot occur, because `rd_bank` is only ever a full bank.
- Control FSM:
  - IDLE: if full[rd_bank] && !(res_valid && !res_ready) -> GO. The start is blocked while an unaccepted result is pending.
  - GO: `go`=1 for exactly this one cycle -> RUN.
  - RUN: wait for `ready`. On `ready`:
    - `res_digit` <= `digit`.
    - `res_frame_id` <= `frame_cnt`, then `frame_cnt`++ (wraps 2**FID_W-1 -> 0).
    - `res_valid` <= 1.
    - full[rd_bank] <= 0 (bank released), `rd_bank` toggles.
    - -> IDLE.
- Result port:
  - `res_valid` clears on `res_valid` && `res_ready`.
  - `res_digit` and `res_frame_id` are stable while `res_valid`=1.
  - A new capture in the same cycle as acceptance takes priority: the new result is loaded and `res_valid` stays 1.
- Earliest `go` after the last pixel is accepted: bank full at edge N, `go` high in cycle N+1.
- Back-to-back frames: the next `go` can follow RUN exit by 1 cycle (IDLE->GO), provided the other bank is full.
- `ready` in IDLE or GO: ignored for data and bank state, sets `err_spurious`. `err_spurious` clears only on reset.
- Reset mid-frame, at any point: the partial frame and both bank flags are discarded, and all state returns to reset values.

Test Plan:
- Stream 1024 beats of `s_data` = i mod 256 after reset -> one `go` pulse, the cycle after the 1024th beat is accepted. Reads: `aa_image`=0x005 with `cena_image`=0 -> `image_q`=0x05 next cycle. `aa_image`=0x3FF -> `image_q`=0xFF. `cena_image`=1 -> `image_q` holds.
- In RUN, pulse `ready` with `digit`=7, `res_ready`=0 -> `res_valid`=1, `res_digit`=7, `res_frame_id`=0, held across 20 cycles. Raise `res_ready` -> `res_valid`=0 the next cycle.
- Stream 3 frames continuously with no `ready` -> 2048 beats accepted, then `s_ready`=0, exactly 1 `go` issued. `ready` -> bank 0 freed, `s_ready`=1, third frame completes, second `go` reads frame-2 data from bank 1.
- 10 frames with `res_ready` tied 1 -> 10 `go` pulses, `res_frame_id` 0..9 in order, each `digit` matches its `ready` cycle. `res_ready`=0 after the first result -> the second `go` is withheld until acceptance.
- `ready` pulsed while in IDLE and in the GO cycle -> `err_spurious`=1, `res_valid` unchanged, bank flags unchanged.
- Assert `rst_n`=0 after 500 beats of a frame -> all outputs 0, `s_ready`=1. A fresh 1024-beat frame then yields `go`, and reads return the new data only.
